// File: rtl/device_uart_if.sv
// Cluster device-bus bundle seen by the UART: strobes, address, write data and registered read data.
interface device_uart_if;
    logic [3:0]  device_core_id;
    logic        device_write_en;
    logic        device_read_en;
    logic [9:0]  device_addr;
    logic [15:0] device_data_out;
    logic [15:0] device_data_in;

    modport master (
        output device_core_id, device_write_en, device_read_en, device_addr, device_data_out,
        input  device_data_in
    );

    modport slave (
        input  device_core_id, device_write_en, device_read_en, device_addr, device_data_out,
        output device_data_in
    );
endinterface

// File: rtl/device_uart.sv
// Memory-mapped 8N1 UART with a TX FIFO shared by all cluster cores.
// Define UART_RX_EN to build the receiver with its one-byte holding register.
module device_uart #(
    parameter int CLOCK_DIVISOR = 868,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic          clk,
    input  logic          reset,
    device_uart_if.slave  bus,
    output logic          uart_tx,
    input  logic          uart_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLOCK_DIVISOR > 2) ? $clog2(CLOCK_DIVISOR) : 1;
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLOCK_DIVISOR - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCK_DIVISOR / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_full, fifo_empty;
    logic          push_req, push_ok, pop;
    tx_state_t     tx_state, tx_state_next;
    logic [CW-1:0] tx_baud, tx_baud_next;
    logic [2:0]    tx_bit, tx_bit_next;
    logic [7:0]    tx_shift, tx_shift_next;
    logic          tx_line_next;
    logic [3:0]    last_core;
    logic          tx_overflow;
    logic          rd_status, rd_rx;
    logic          rx_valid, rx_overrun;
    logic [7:0]    rx_byte;
    logic [15:0]   rd_data;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req   = bus.device_write_en && (bus.device_addr[1:0] == 2'd1);
    assign push_ok    = push_req && (!fifo_full || pop);
    assign rd_status  = bus.device_read_en && (bus.device_addr[1:0] == 2'd0);
    assign rd_rx      = bus.device_read_en && (bus.device_addr[1:0] == 2'd2);

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr[AW-1:0]] <= bus.device_data_out[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_core   <= 4'h0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_core <= bus.device_core_id;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // A dropped push in the same cycle as a STATUS read stays visible next read
            if (push_req && !push_ok)
                tx_overflow <= 1'b1;
            else if (rd_status)
                tx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_baud  <= tx_baud_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            uart_tx  <= tx_line_next;
        end
    end

    // Line level is computed from the next state so uart_tx is a clean flop output
    always_comb begin
        tx_state_next = tx_state;
        tx_baud_next  = tx_baud;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_line_next  = 1'b1;
        pop           = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    tx_shift_next = fifo_mem[rd_ptr[AW-1:0]];
                    tx_baud_next  = BAUD_LOAD;
                    tx_state_next = TX_START;
                    tx_line_next  = 1'b0;
                end
            end
            TX_START: begin
                tx_line_next = 1'b0;
                if (tx_baud == '0) begin
                    tx_state_next = TX_DATA;
                    tx_baud_next  = BAUD_LOAD;
                    tx_bit_next   = 3'd0;
                    tx_line_next  = tx_shift[0];
                end else begin
                    tx_baud_next = tx_baud - 1'b1;
                end
            end
            TX_DATA: begin
                tx_line_next = tx_shift[0];
                if (tx_baud == '0) begin
                    tx_baud_next = BAUD_LOAD;
                    if (tx_bit == 3'd7) begin
                        tx_state_next = TX_STOP;
                        tx_line_next  = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit + 3'd1;
                        tx_shift_next = {1'b0, tx_shift[7:1]};
                        tx_line_next  = tx_shift[1];
                    end
                end else begin
                    tx_baud_next = tx_baud - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_baud == '0) begin
                    // Chain straight into the next frame so queued bytes leave without a gap
                    if (!fifo_empty) begin
                        pop           = 1'b1;
                        tx_shift_next = fifo_mem[rd_ptr[AW-1:0]];
                        tx_baud_next  = BAUD_LOAD;
                        tx_state_next = TX_START;
                        tx_line_next  = 1'b0;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    tx_baud_next = tx_baud - 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_state_next;
    logic          rx_meta, rx_sync, rx_last;
    logic [CW-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]    rx_bit, rx_bit_next;
    logic [7:0]    rx_shift, rx_shift_next;
    logic          rx_done;
    logic [6:0]    unused_bits;

    assign unused_bits = {bus.device_addr[9:2] == 8'h00, bus.device_data_out[15:10]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_last    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_shift   <= 8'h00;
            rx_byte    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_last  <= rx_sync;
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
            // A byte landing on the same edge as an RX_DATA read replaces the one being read
            if (rx_done) begin
                rx_byte    <= rx_shift;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid && !rd_rx;
            end else if (rd_rx) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_done       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_last && !rx_sync) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_state_next = RX_DATA;
                        rx_cnt_next   = BAUD_LOAD;
                        rx_bit_next   = 3'd0;
                    end
                end else begin
                    rx_cnt_next = rx_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    rx_cnt_next   = BAUD_LOAD;
                    if (rx_bit == 3'd7)
                        rx_state_next = RX_STOP;
                    else
                        rx_bit_next = rx_bit + 3'd1;
                end else begin
                    rx_cnt_next = rx_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_done       = 1'b1;
                    rx_state_next = RX_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt - 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end
`else
    logic [7:0] unused_bits;

    assign unused_bits = {bus.device_addr[9:2] == 8'h00, bus.device_data_out[15:10], uart_rx};
    assign rx_valid    = 1'b0;
    assign rx_overrun  = 1'b0;
    assign rx_byte     = 8'h00;
`endif

    always_comb begin
        rd_data = 16'h0000;
        case (bus.device_addr[1:0])
            2'd0: rd_data = {10'h000, tx_overflow, rx_overrun, rx_valid,
                             tx_state != TX_IDLE, fifo_empty, fifo_full};
            2'd2: rd_data = {8'h00, rx_byte};
            2'd3: rd_data = {12'h000, last_core};
            default: rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.device_data_in <= 16'h0000;
        else if (bus.device_read_en)
            bus.device_data_in <= rd_data;
    end
endmodule

// File: tb/tb_device_uart.sv
// Directed self-checking bench for device_uart with CLOCK_DIVISOR=4, FIFO_DEPTH=8.
// Receiver checks switch with UART_RX_EN, matching the design build.
module tb_device_uart;
    localparam int DIV = 4;

    logic clk;
    logic reset;
    logic uart_tx;
    logic uart_rx;
    int   errors;
    int   checks;
    logic tx_log[$];

    device_uart_if bus_if();

    device_uart #(.CLOCK_DIVISOR(DIV), .FIFO_DEPTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if.slave),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One uart_tx sample per cycle, taken just after each rising edge
    always @(posedge clk) begin
        #1;
        tx_log.push_back(uart_tx);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [9:0] addr, input logic [15:0] data, input logic [3:0] core);
        bus_if.device_addr     = addr;
        bus_if.device_data_out = data;
        bus_if.device_core_id  = core;
        bus_if.device_write_en = 1'b1;
        @(negedge clk);
        bus_if.device_write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [9:0] addr, output logic [15:0] rdata);
        bus_if.device_addr    = addr;
        bus_if.device_read_en = 1'b1;
        @(negedge clk);
        bus_if.device_read_en = 1'b0;
        rdata = bus_if.device_data_in;
    endtask

    task automatic send_byte(input logic [7:0] val);
        logic [9:0] frame;
        frame = {1'b1, val, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = frame[k];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_tx: got %b, need 1", uart_tx);
        end
        checks++;
        if (bus_if.device_data_in !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_data_in: got %h, need 0000", bus_if.device_data_in);
        end
        reset = 1'b0;
        @(negedge clk);
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h, need 0002", rd);
        end
        bus_read(10'h3FC, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL alias_status: got %h, need 0002", rd);
        end
        bus_read(10'h003, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_last_core: got %h, need 0000", rd);
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] rd;
        logic [9:0]  frame;
        int base;
        frame = {1'b1, 8'h55, 1'b0};
        base = tx_log.size();
        bus_write(10'h001, 16'h1A55, 4'd5);
        idle_cycles(45);
        checks++;
        if (tx_log[base] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_pre_start: got %b, need 1", tx_log[base]);
        end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < DIV; j++) begin
                checks++;
                if (tx_log[base + 1 + k*DIV + j] !== frame[k]) begin
                    errors++;
                    $display("[TB] FAIL single_bit%0d_cyc%0d: got %b, need %b",
                             k, j, tx_log[base + 1 + k*DIV + j], frame[k]);
                end
            end
        end
        checks++;
        if (tx_log[base + 41] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_post_idle: got %b, need 1", tx_log[base + 41]);
        end
        bus_read(10'h003, rd);
        checks++;
        if (rd !== 16'h0005) begin
            errors++;
            $display("[TB] FAIL single_last_core: got %h, need 0005", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        logic [7:0]  val;
        logic        exp;
        int base;
        int idx;
        base = tx_log.size();
        for (int i = 0; i < 9; i++)
            bus_write(10'h001, 16'hFF00 | 16'(i), 4'd3);
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0005) begin
            errors++;
            $display("[TB] FAIL b2b_full_status: got %h, need 0005", rd);
        end
        bus_write(10'h001, 16'h0009, 4'd7);
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0025) begin
            errors++;
            $display("[TB] FAIL b2b_overflow_status: got %h, need 0025", rd);
        end
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0005) begin
            errors++;
            $display("[TB] FAIL b2b_overflow_cleared: got %h, need 0005", rd);
        end
        bus_read(10'h003, rd);
        checks++;
        if (rd !== 16'h0003) begin
            errors++;
            $display("[TB] FAIL b2b_last_core: got %h, need 0003", rd);
        end
        idle_cycles(360);
        for (int f = 0; f < 9; f++) begin
            val = 8'(f);
            for (int k = 0; k < 10; k++) begin
                exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : val[k-1];
                idx = base + 1 + (f*10 + k)*DIV + 2;
                checks++;
                if (tx_log[idx] !== exp) begin
                    errors++;
                    $display("[TB] FAIL b2b_frame%0d_bit%0d: got %b, need %b", f, k, tx_log[idx], exp);
                end
            end
        end
        checks++;
        if (tx_log[base + 361] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_no_tenth_frame: got %b, need 1", tx_log[base + 361]);
        end
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL b2b_final_status: got %h, need 0002", rd);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] rd;
        int base;
        int lows;
        for (int i = 0; i < 4; i++)
            bus_write(10'h001, 16'h0000, 4'd2);
        idle_cycles(6);
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_data_low: got %b, need 0", uart_tx);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midframe_async_tx: got %b, need 1", uart_tx);
        end
        checks++;
        if (bus_if.device_data_in !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midframe_data_in: got %h, need 0000", bus_if.device_data_in);
        end
        @(negedge clk);
        reset = 1'b0;
        base = tx_log.size();
        idle_cycles(60);
        lows = 0;
        for (int i = base; i < tx_log.size(); i++)
            if (tx_log[i] !== 1'b1) lows++;
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("[TB] FAIL midframe_no_frames: got %0d low cycles, need 0", lows);
        end
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL midframe_status: got %h, need 0002", rd);
        end
    endtask

    task automatic test_write_read_together();
        logic [15:0] rd;
        bus_if.device_addr     = 10'h001;
        bus_if.device_data_out = 16'h0081;
        bus_if.device_core_id  = 4'd9;
        bus_if.device_write_en = 1'b1;
        bus_if.device_read_en  = 1'b1;
        @(negedge clk);
        bus_if.device_write_en = 1'b0;
        bus_if.device_read_en  = 1'b0;
        checks++;
        if (bus_if.device_data_in !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wr_rd_txdata_read: got %h, need 0000", bus_if.device_data_in);
        end
        bus_read(10'h003, rd);
        checks++;
        if (rd !== 16'h0009) begin
            errors++;
            $display("[TB] FAIL wr_rd_last_core: got %h, need 0009", rd);
        end
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0006) begin
            errors++;
            $display("[TB] FAIL wr_rd_busy_status: got %h, need 0006", rd);
        end
        idle_cycles(45);
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL wr_rd_done_status: got %h, need 0002", rd);
        end
    endtask

`ifdef UART_RX_EN
    task automatic test_rx();
        logic [15:0] rd;
        send_byte(8'hC3);
        idle_cycles(4);
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h000A) begin
            errors++;
            $display("[TB] FAIL rx_valid_status: got %h, need 000A", rd);
        end
        bus_read(10'h002, rd);
        checks++;
        if (rd !== 16'h00C3) begin
            errors++;
            $display("[TB] FAIL rx_data: got %h, need 00C3", rd);
        end
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL rx_cleared_status: got %h, need 0002", rd);
        end
        send_byte(8'h11);
        send_byte(8'h22);
        idle_cycles(4);
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h001A) begin
            errors++;
            $display("[TB] FAIL rx_overrun_status: got %h, need 001A", rd);
        end
        bus_read(10'h002, rd);
        checks++;
        if (rd !== 16'h0022) begin
            errors++;
            $display("[TB] FAIL rx_overrun_data: got %h, need 0022", rd);
        end
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL rx_overrun_cleared: got %h, need 0002", rd);
        end
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        idle_cycles(20);
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL rx_glitch_status: got %h, need 0002", rd);
        end
    endtask
`else
    task automatic test_rx();
        logic [15:0] rd;
        send_byte(8'h5A);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        idle_cycles(8);
        bus_read(10'h000, rd);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL norx_status: got %h, need 0002", rd);
        end
        bus_read(10'h002, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL norx_data: got %h, need 0000", rd);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        uart_rx = 1'b1;
        bus_if.device_core_id  = 4'h0;
        bus_if.device_write_en = 1'b0;
        bus_if.device_read_en  = 1'b0;
        bus_if.device_addr     = 10'h000;
        bus_if.device_data_out = 16'h0000;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_write_read_together();
        test_rx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
